// File: rtl/alu_pipe.sv
// alu_pipe: single-stage registered ALU with valid/ready handshakes on both
// sides. It keeps an accumulator and a stored carry so that wide operations
// can be chained across several narrow ones.
module alu_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [2:0]       select,
    input  logic             use_acc,
    input  logic             chain_carry,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH-1:0] acc;
    logic             carry_reg;

    logic             accept;
    logic [WIDTH-1:0] acc_eff;
    logic             carry_eff;
    logic [WIDTH-1:0] op_a;
    logic             op_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;

    // A single result register, so a new operation fits whenever the current result leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A clear in the same cycle as an accept means the operation sees a zeroed accumulator.
    assign acc_eff   = acc_clear ? '0 : acc;
    assign carry_eff = acc_clear ? 1'b0 : carry_reg;
    assign op_a      = use_acc ? acc_eff : a;
    assign op_cin    = chain_carry ? carry_eff : carry_in;

    // One extra bit on the adder/subtractor captures the carry or the unsigned borrow.
    assign sum  = {1'b0, op_a} + {1'b0, b} + {{WIDTH{1'b0}}, op_cin};
    assign diff = {1'b0, op_a} - {1'b0, b} - {{WIDTH{1'b0}}, op_cin};

    // Opcode decode into the result and its carry/overflow flags.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        unique case (select)
            3'd7: begin
                res       = op_a & b;
                res_carry = 1'b1;
            end
            3'd6: begin
                res       = ~op_a;
                res_carry = 1'b1;
            end
            3'd5: begin
                res       = op_a | b;
                res_carry = 1'b1;
            end
            3'd4: begin
                res       = op_a ^ b;
                res_carry = 1'b1;
            end
            3'd3: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (op_a[WIDTH-1] == b[WIDTH-1]) &&
                            (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'd2: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_ovf   = (op_a[WIDTH-1] != b[WIDTH-1]) &&
                            (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            3'd1: begin
                res       = op_a;
            end
            default: begin
                res       = ~(op_a ^ b);
            end
        endcase
    end

    // Result register, output handshake and accumulator/carry state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            carry_reg <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= res;
            carry_out <= res_carry;
            zero      <= (res == '0);
            negative  <= res[WIDTH-1];
            overflow  <= res_ovf;
            acc       <= res;
            carry_reg <= res_carry;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc_clear) begin
                acc       <= '0;
                carry_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scenarios plus a randomized run against an
// arithmetic reference model of the 4-bit ALU pipeline.
module tb_alu_pipe;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       carry_in;
    logic [2:0] select;
    logic       use_acc;
    logic       chain_carry;
    logic       acc_clear;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;

    int vectors;
    int miscompares;

    // Reference model state: accumulator value and stored carry as plain integers.
    int m_acc;
    int m_creg;

    alu_pipe #(.WIDTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .carry_in(carry_in),
        .select(select),
        .use_acc(use_acc),
        .chain_carry(chain_carry),
        .acc_clear(acc_clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .carry_out(carry_out),
        .zero(zero),
        .negative(negative),
        .overflow(overflow)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of one accepted operation; returns {out, carry, zero, negative, overflow}.
    function automatic logic [7:0] model_op(input int av_in, input int bv, input int cin_in,
                                            input int sel, input bit ua, input bit ch,
                                            input bit clr);
        int av, ci, r, sa, sb, s;
        bit c, v;
        logic [3:0] r4;
        if (clr) begin
            m_acc  = 0;
            m_creg = 0;
        end
        av = ua ? m_acc : av_in;
        ci = ch ? m_creg : cin_in;
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (sel)
            7: begin r = av & bv;           c = 1'b1; end
            6: begin r = (~av) & 15;        c = 1'b1; end
            5: begin r = av | bv;           c = 1'b1; end
            4: begin r = av ^ bv;           c = 1'b1; end
            3: begin
                s = av + bv + ci;
                r = s % 16;
                c = (s >= 16);
                v = ((sa + sb + ci) > 7) || ((sa + sb + ci) < -8);
            end
            2: begin
                s = av - bv - ci;
                r = (s + 32) % 16;
                c = (av < bv + ci);
                v = ((sa - sb - ci) > 7) || ((sa - sb - ci) < -8);
            end
            1: begin r = av; end
            default: begin r = (~(av ^ bv)) & 15; end
        endcase
        m_acc  = r;
        m_creg = c;
        r4 = r[3:0];
        return {r4, c, (r == 0), (r >= 8), v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation for a single cycle; caller ensures in_ready is high.
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic tcin,
                         input logic [2:0] tsel, input logic tua, input logic tch,
                         input logic tclr);
        a           = ta;
        b           = tb_v;
        carry_in    = tcin;
        select      = tsel;
        use_acc     = tua;
        chain_carry = tch;
        acc_clear   = tclr;
        in_valid    = 1'b1;
        step();
        in_valid    = 1'b0;
        acc_clear   = 1'b0;
        use_acc     = 1'b0;
        chain_carry = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        vectors++;
        if ({out_valid, in_ready, out, carry_out, zero, negative, overflow} !== 10'b01_0000_0000) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b expected %b",
                     {out_valid, in_ready, out, carry_out, zero, negative, overflow}, 10'b01_0000_0000);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL after_reset: got valid/ready %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_arith();
        logic [7:0] exp_v [3];
        logic [7:0] got;
        exp_v[0] = {4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
        exp_v[1] = {4'd14, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_v[2] = {4'd8,  1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: issue(4'd7, 4'd9, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
                1: issue(4'd3, 4'd5, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
                default: issue(4'd7, 4'd1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
            endcase
            got = {out, carry_out, zero, negative, overflow};
            vectors++;
            if (!out_valid || got !== exp_v[i]) begin
                miscompares++;
                $display("[TB] FAIL arith_%0d: got valid=%b %b expected valid=1 %b",
                         i, out_valid, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_chain();
        logic [7:0] got;
        out_ready = 1'b1;
        issue(4'd12, 4'd15, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1);
        got = {out, carry_out, zero, negative, overflow};
        vectors++;
        if (got !== {4'd11, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL chain_low: got %b expected %b", got, {4'd11, 4'b1010});
        end
        issue(4'd3, 4'd5, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
        got = {out, carry_out, zero, negative, overflow};
        vectors++;
        if (got !== {4'd9, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL chain_high: got %b expected %b", got, {4'd9, 4'b0011});
        end
    endtask

    task automatic test_accumulator();
        logic [7:0] exp_v [4];
        logic [7:0] got;
        exp_v[0] = {4'd5,  4'b0000};
        exp_v[1] = {4'd10, 4'b0011};
        exp_v[2] = {4'd15, 4'b0010};
        exp_v[3] = {4'd4,  4'b1000};
        out_ready = 1'b1;
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(4'($urandom_range(15)), 4'd5, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
            got = {out, carry_out, zero, negative, overflow};
            vectors++;
            if (got !== exp_v[i]) begin
                miscompares++;
                $display("[TB] FAIL acc_%0d: got %b expected %b", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        a = 4'd2; b = 4'd6; select = 3'd4; carry_in = 1'b0;
        in_valid = 1'b1;
        step();
        a = 4'd5; b = 4'd3; select = 3'd5;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({out_valid, in_ready, out, carry_out} !== {1'b1, 1'b0, 4'd4, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL hold_%0d: got valid=%b ready=%b out=%0d c=%b expected 1 0 4 1",
                         i, out_valid, in_ready, out, carry_out);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_release: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out, carry_out} !== {1'b1, 4'd7, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL second_result: got valid=%b out=%0d c=%b expected 1 7 1",
                     out_valid, out, carry_out);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        logic [7:0] got;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        issue(4'd7, 4'd4, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({out_valid, out} !== {1'b1, 4'd11}) begin
            miscompares++;
            $display("[TB] FAIL inflight_held: got valid=%b out=%0d expected 1 11", out_valid, out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_ready, out, carry_out, zero, negative, overflow} !== 10'b01_0000_0000) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %b expected %b",
                     {out_valid, in_ready, out, carry_out, zero, negative, overflow}, 10'b01_0000_0000);
        end
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_stale_result: got valid=%b expected 0", out_valid);
        end
        issue(4'd9, 4'd3, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        got = {out, carry_out, zero, negative, overflow};
        vectors++;
        if (got !== {4'd3, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL acc_after_reset: got %b expected %b", got, {4'd3, 4'b0000});
        end
    endtask

    task automatic test_random();
        bit         exp_valid;
        bit         acc_now;
        logic [7:0] exp_r;
        logic [7:0] got;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        m_acc     = 0;
        m_creg    = 0;
        exp_valid = 1'b0;
        exp_r     = '0;
        for (int i = 0; i < 400; i++) begin
            a           = 4'($urandom_range(15));
            b           = 4'($urandom_range(15));
            carry_in    = 1'($urandom_range(1));
            select      = 3'($urandom_range(7));
            use_acc     = 1'($urandom_range(1));
            chain_carry = 1'($urandom_range(1));
            acc_clear   = ($urandom_range(7) == 0);
            in_valid    = ($urandom_range(3) != 0);
            out_ready   = ($urandom_range(2) != 0);
            #1;
            vectors++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                miscompares++;
                $display("[TB] FAIL rand_ready_%0d: got %b expected %b",
                         i, in_ready, (!exp_valid || out_ready));
            end
            acc_now = in_valid && (!exp_valid || out_ready);
            if (acc_now) begin
                exp_r = model_op(int'(a), int'(b), int'(carry_in), int'(select),
                                 use_acc, chain_carry, acc_clear);
                exp_valid = 1'b1;
            end else begin
                if (acc_clear) begin
                    m_acc  = 0;
                    m_creg = 0;
                end
                if (out_ready) exp_valid = 1'b0;
            end
            step();
            got = {out, carry_out, zero, negative, overflow};
            vectors++;
            if (out_valid !== exp_valid || (exp_valid && got !== exp_r)) begin
                miscompares++;
                $display("[TB] FAIL rand_out_%0d: got valid=%b %b expected valid=%b %b",
                         i, out_valid, got, exp_valid, exp_r);
            end
        end
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b1;
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        m_acc       = 0;
        m_creg      = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        carry_in    = 1'b0;
        select      = '0;
        use_acc     = 1'b0;
        chain_carry = 1'b0;
        acc_clear   = 1'b0;
        out_ready   = 1'b1;
        #2;
        test_reset();
        test_arith();
        test_chain();
        test_accumulator();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
